reg_file_mp: RTL and testbench

//  Parametrised multi-read-port register file; next generation of the 8x16 CPU register file.

---
 rtl/reg_file_mp_pkg.sv | 5 +
 rtl/reg_file_mp_if.sv | 18 +
 rtl/reg_file_mp_clear_seq.sv | 51 +++++
 rtl/reg_file_mp.sv | 77 +++++++
 tb/tb_reg_file_mp.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared types and constants for the multi-read-port register file.
package rf_pkg;
   typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
   localparam int RF_ZERO_ADDR = 0;
endpackage

// File: rtl/reg_file_mp_if.sv
// Write/read bus of the register file: writeback drives the write port, decode drives read addresses.
interface reg_file_mp_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int NRD   = 2
);
   localparam int AW = $clog2(DEPTH);

   logic                 WE;
   logic [AW-1:0]        WA;
   logic [WIDTH-1:0]     WD;
   logic [NRD*AW-1:0]    RA;
   logic [NRD*WIDTH-1:0] RD;
   logic                 READY;

   modport master (output WE, WA, WD, RA, input RD, READY);
   modport slave  (input WE, WA, WD, RA, output RD, READY);
endinterface

// File: rtl/reg_file_mp_clear_seq.sv
// Post-reset clear sweep: walks entries 1..DEPTH-1 writing zero, then raises ready.
module rf_clear_seq
   import rf_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RST_N,
   output logic          clr_we,
   output logic [AW-1:0] clr_addr,
   output logic          ready
);

   localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

   rf_state_t state;

   // Entry 0 is never stored, so the sweep starts at 1 and stops at the last entry.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= RF_CLEAR;
         clr_addr <= AW'(1);
         clr_we   <= 1'b1;
         ready    <= 1'b0;
      end else begin
         case (state)
            RF_CLEAR: begin
               if (clr_addr == LAST_IDX) begin
                  state  <= RF_RUN;
                  clr_we <= 1'b0;
                  ready  <= 1'b1;
               end else begin
                  clr_addr <= clr_addr + 1'b1;
               end
            end
            RF_RUN: begin
               clr_we <= 1'b0;
               ready  <= 1'b1;
            end
            default: begin
               state    <= RF_CLEAR;
               clr_addr <= AW'(1);
               clr_we   <= 1'b1;
               ready    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file with NRD combinational read ports and a hardware clear sweep.
// Optional same-cycle write forwarding is built when RF_WRITE_BYPASS_EN is defined.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          CLK,
   input  logic          RST_N,
   reg_file_mp_if.slave  bus
);

   localparam logic [AW-1:0] ZERO_ADDR = AW'(RF_ZERO_ADDR);

   logic             clr_we;
   logic [AW-1:0]    clr_addr;
   logic             ready;
   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic [WIDTH-1:0] wr_data;
   logic [WIDTH-1:0] mem [0:DEPTH-1];

   rf_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .clr_we   (clr_we),
      .clr_addr (clr_addr),
      .ready    (ready)
   );

   // The sweep owns the write port until ready; user writes during that time are dropped.
   always_comb begin
      wr_en   = 1'b0;
      wr_addr = clr_addr;
      wr_data = '0;
      if (clr_we) begin
         wr_en = 1'b1;
      end else if (ready && bus.WE && (bus.WA != ZERO_ADDR)) begin
         wr_en   = 1'b1;
         wr_addr = bus.WA;
         wr_data = bus.WD;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST_N && wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign bus.READY = ready;

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0]    ra_i;
      logic [WIDTH-1:0] rd_i;

      assign ra_i = bus.RA[i*AW +: AW];

      always_comb begin
         rd_i = '0;
         if (ready && (ra_i != ZERO_ADDR)) begin
            rd_i = mem[ra_i];
`ifdef RF_WRITE_BYPASS_EN
            if (bus.WE && (bus.WA == ra_i)) begin
               rd_i = bus.WD;
            end
`endif
         end
      end

      assign bus.RD[i*WIDTH +: WIDTH] = rd_i;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp: directed scenarios plus randomized traffic against a reference model.
module tb_reg_file_mp;

   localparam int W  = 8;
   localparam int D  = 16;
   localparam int N  = 2;
   localparam int A  = 4;
   localparam int W2 = 16;
   localparam int D2 = 32;
   localparam int N2 = 3;
   localparam int A2 = 5;

   logic CLK = 1'b0;
   logic rst_n;
   logic rst2_n;
   int   checks = 0;
   int   errors = 0;

   always #5 CLK = ~CLK;

   reg_file_mp_if #(.WIDTH(W),  .DEPTH(D),  .NRD(N))  bus1 ();
   reg_file_mp_if #(.WIDTH(W2), .DEPTH(D2), .NRD(N2)) bus2 ();

   reg_file_mp #(.WIDTH(W), .DEPTH(D), .NRD(N)) dut1 (
      .CLK   (CLK),
      .RST_N (rst_n),
      .bus   (bus1)
   );

   reg_file_mp #(.WIDTH(W2), .DEPTH(D2), .NRD(N2)) dut2 (
      .CLK   (CLK),
      .RST_N (rst2_n),
      .bus   (bus2)
   );

   // Reference model of dut1: contents, readiness and edges since reset release.
   logic [W-1:0] mref [D];
   bit           rready = 1'b0;
   int           redges = 0;

   function automatic logic [W-1:0] exp_rd(int a);
      if (!rready || a == 0) return '0;
`ifdef RF_WRITE_BYPASS_EN
      if (bus1.WE && int'(bus1.WA) == a) return bus1.WD;
`endif
      return mref[a];
   endfunction

   task automatic cyc();
      @(posedge CLK);
      if (!rst_n) begin
         rready = 1'b0;
         redges = 0;
      end else if (!rready) begin
         redges++;
         if (redges == D - 1) begin
            rready = 1'b1;
            for (int k = 0; k < D; k++) mref[k] = '0;
         end
      end else if (bus1.WE && bus1.WA != 0) begin
         mref[bus1.WA] = bus1.WD;
      end
      #1;
   endtask

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic set_ra(int a0, int a1);
      bus1.RA = {A'(a1), A'(a0)};
      #1;
   endtask

   task automatic chk_ports(string tag);
      for (int i = 0; i < N; i++)
         chk($sformatf("%s.rd%0d", tag, i), 64'(bus1.RD[i*W +: W]),
             64'(exp_rd(int'(bus1.RA[i*A +: A]))));
      chk($sformatf("%s.ready", tag), 64'(bus1.READY), 64'(rready));
   endtask

   task automatic chk_all_zero(string tag);
      for (int a = 0; a < D; a++) begin
         set_ra(a, D - 1 - a);
         chk($sformatf("%s.a%0d", tag, a), 64'(bus1.RD[0 +: W]), 64'd0);
         chk_ports(tag);
      end
   endtask

   initial begin
      rst_n = 1'b0;  rst2_n = 1'b0;
      bus1.WE = 1'b0; bus1.WA = '0; bus1.WD = '0; bus1.RA = '0;
      bus2.WE = 1'b0; bus2.WA = '0; bus2.WD = '0; bus2.RA = '0;

      // 1: reset sweep
      for (int c = 0; c < 2; c++) begin
         cyc();
         set_ra(c + 1, 9);
         chk("t1.rst_ready", 64'(bus1.READY), 64'd0);
         chk_ports("t1.rst");
      end
      rst_n = 1'b1;
      for (int e = 1; e <= D - 1; e++) begin
         cyc();
         chk($sformatf("t1.ready_e%0d", e), 64'(bus1.READY), 64'(e == D - 1));
      end
      cyc();
      chk("t1.ready_after", 64'(bus1.READY), 64'd1);
      chk_all_zero("t1.zero");

      // 2: write then read on both ports
      bus1.WE = 1'b1; bus1.WA = 4'd5; bus1.WD = 8'hA5;
      set_ra(5, 5);
`ifdef RF_WRITE_BYPASS_EN
      chk("t2.pre", 64'(bus1.RD), 64'hA5A5);
`else
      chk("t2.pre", 64'(bus1.RD), 64'h0000);
`endif
      chk_ports("t2.pre_m");
      cyc();
      bus1.WE = 1'b0;
      set_ra(5, 5);
      chk("t2.post", 64'(bus1.RD), 64'hA5A5);

      // 3: zero register ignores writes
      bus1.WE = 1'b1; bus1.WA = 4'd0; bus1.WD = 8'hFF;
      set_ra(0, 5);
      chk("t3.pre", 64'(bus1.RD), 64'hA500);
      cyc();
      bus1.WE = 1'b0;
      set_ra(0, 5);
      chk("t3.post", 64'(bus1.RD), 64'hA500);
      for (int a = 1; a < D; a++) begin
         set_ra(a, 0);
         chk($sformatf("t3.a%0d", a), 64'(bus1.RD[0 +: W]), 64'(a == 5 ? 8'hA5 : 8'h00));
      end

      // 4: write during clear is dropped
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      bus1.WE = 1'b1; bus1.WA = 4'd3; bus1.WD = 8'h3C;
      cyc();
      bus1.WE = 1'b0;
      chk("t4.notready", 64'(bus1.READY), 64'd0);
      for (int g = 0; g < 40 && !bus1.READY; g++) cyc();
      chk("t4.ready", 64'(bus1.READY), 64'd1);
      chk("t4.edges", 64'(redges), 64'(D - 1));
      set_ra(3, 3);
      chk("t4.rd3", 64'(bus1.RD), 64'h0000);

      // 5: reset in the middle of normal operation
      for (int a = 1; a < D; a++) begin
         bus1.WE = 1'b1; bus1.WA = A'(a); bus1.WD = 8'h11;
         cyc();
      end
      bus1.WE = 1'b0;
      set_ra(1, D - 1);
      chk("t5.filled", 64'(bus1.RD), 64'h1111);
      rst_n = 1'b0;
      bus1.WE = 1'b1; bus1.WA = 4'd7; bus1.WD = 8'h77;
      cyc();
      rst_n = 1'b1;
      bus1.WE = 1'b0;
      chk("t5.drop", 64'(bus1.READY), 64'd0);
      for (int e = 1; e <= D - 1; e++) begin
         cyc();
         chk($sformatf("t5.ready_e%0d", e), 64'(bus1.READY), 64'(e == D - 1));
      end
      chk_all_zero("t5.zero");

      // Randomized traffic, including occasional resets
      for (int r = 0; r < 400; r++) begin
         rst_n   = ($urandom_range(0, 59) != 0);
         bus1.WE = 1'($urandom);
         bus1.WA = A'($urandom);
         bus1.WD = W'($urandom);
         bus1.RA = (A*N)'($urandom);
         if ($urandom_range(0, 3) == 0) bus1.RA[A +: A] = bus1.WA;
         #1;
         chk_ports($sformatf("rnd%0d", r));
         cyc();
      end
      rst_n = 1'b1;
      bus1.WE = 1'b0;

      // 6: wider, deeper, three read ports
      cyc();
      rst2_n = 1'b1;
      for (int e = 1; e <= D2 - 1; e++) begin
         cyc();
         chk($sformatf("t6.ready_e%0d", e), 64'(bus2.READY), 64'(e == D2 - 1));
      end
      bus2.WE = 1'b1; bus2.WA = 5'd31; bus2.WD = 16'hBEEF;
      cyc();
      bus2.WE = 1'b0;
      bus2.RA = {A2'(31), A2'(31), A2'(31)};
      #1;
      for (int i = 0; i < N2; i++)
         chk($sformatf("t6.rd%0d", i), 64'(bus2.RD[i*W2 +: W2]), 64'hBEEF);
      bus2.RA = {A2'(31), A2'(30), A2'(0)};
      #1;
      chk("t6.mixed", 64'(bus2.RD), 64'hBEEF_0000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
